lif_neuron_array: RTL

- Parametrised successor to the single-neuron LIF block: N_NEURONS independent leaky integrate-and-fire neurons advanced together, one timestep per accepted request.
- Adds configurable width, leak shift, refractory period, membrane persistence across timesteps, saturating arithmetic and a valid/ack output handshake.
- Sits between the synaptic current accumulator, which feeds input_current, and the spike router, which consumes spike_vec.

---
 rtl/lif_neuron_array.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/lif_neuron_array.sv
// lif_neuron_array
//   N_NEURONS leaky integrate-and-fire neurons, all advanced by one timestep
//   for each accepted step request. Results go out on a valid/ack handshake.
//
//   Optional build macro: LIF_SAT_EN
//     defined   : the membrane update sum saturates at 2^WIDTH-1
//     undefined : the membrane update sum wraps modulo 2^WIDTH
//
//   Ports
//     clk            clock, rising edge
//     rst_n          asynchronous active-low reset
//     step_valid     request one timestep (input_current valid with it)
//     step_ready     high in IDLE; step accepted on step_valid && step_ready
//     input_current  per-neuron current, neuron i at [i*WIDTH +: WIDTH]
//     clear          zero all membranes/refractory counters, IDLE only
//     spike_valid    spike_vec valid, held until acknowledged
//     spike_vec      bit i = neuron i fired this timestep
//     spike_ack      result consumed on spike_valid && spike_ack
//
//   state     | meaning
//   ----------+---------------------------------------------------
//   IDLE      | ready for a step; clear is honoured here
//   INTEGRATE | one cycle: update every neuron, latch spike_vec
//   FIRE      | spike_valid high, hold spike_vec until spike_ack
module lif_neuron_array #(
  parameter int N_NEURONS      = 4,
  parameter int WIDTH          = 16,
  parameter int THRESHOLD      = 58,
  parameter int LEAK_SHIFT     = 1,
  parameter int REFRACT_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         step_valid,
  output logic                         step_ready,
  input  logic [N_NEURONS*WIDTH-1:0]   input_current,
  input  logic                         clear,
  output logic                         spike_valid,
  output logic [N_NEURONS-1:0]         spike_vec,
  input  logic                         spike_ack
);

  localparam int RW = (REFRACT_CYCLES < 1) ? 1 : $clog2(REFRACT_CYCLES + 1);
  localparam logic [WIDTH-1:0] THR       = WIDTH'(THRESHOLD);
  localparam logic [RW-1:0]    REFR_LOAD = RW'(REFRACT_CYCLES);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    INTEGRATE = 2'd1,
    FIRE      = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [N_NEURONS*WIDTH-1:0] in_q;
  logic [N_NEURONS*WIDTH-1:0] v_q;
  logic [N_NEURONS*WIDTH-1:0] v_nxt;
  logic [N_NEURONS*RW-1:0]    refr_q;
  logic [N_NEURONS*RW-1:0]    refr_nxt;
  logic [N_NEURONS-1:0]       spk_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    step_ready  = 1'b0;
    spike_valid = 1'b0;
    case (state)
      IDLE: begin
        step_ready = 1'b1;
        if (step_valid) state_nxt = INTEGRATE;
      end
      INTEGRATE: state_nxt = FIRE;
      FIRE: begin
        spike_valid = 1'b1;
        if (spike_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // clear and a step accepted on the same edge: the membranes are zeroed
  // here while the input is captured, so INTEGRATE starts from v=0, refr=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q      <= '0;
      v_q       <= '0;
      refr_q    <= '0;
      spike_vec <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clear) begin
            v_q    <= '0;
            refr_q <= '0;
          end
          if (step_valid) in_q <= input_current;
        end
        INTEGRATE: begin
          v_q       <= v_nxt;
          refr_q    <= refr_nxt;
          spike_vec <= spk_nxt;
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < N_NEURONS; i++) begin : g_neuron
    logic [WIDTH-1:0] v_cur;
    logic [WIDTH-1:0] v_leak;
    logic [WIDTH-1:0] in_cur;
    logic [WIDTH-1:0] red;
    logic [RW-1:0]    r_cur;
    logic             refr_active;
    logic             fire;

    assign v_cur       = v_q[i*WIDTH +: WIDTH];
    assign in_cur      = in_q[i*WIDTH +: WIDTH];
    assign r_cur       = refr_q[i*RW +: RW];
    assign v_leak      = v_cur >> LEAK_SHIFT;
    assign refr_active = (r_cur != '0);

`ifdef LIF_SAT_EN
    logic [WIDTH:0] sum;
    assign sum = {1'b0, v_leak} + {1'b0, in_cur};
    assign red = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
    // carry out of the WIDTH-bit add is dropped: wrap modulo 2^WIDTH
    assign red = v_leak + in_cur;
`endif

    assign fire       = !refr_active && (red >= THR);
    assign spk_nxt[i] = fire;
    assign v_nxt[i*WIDTH +: WIDTH] = (refr_active || fire) ? '0 : red;
    assign refr_nxt[i*RW +: RW]    = refr_active ? (r_cur - RW'(1)) :
                                     fire        ? REFR_LOAD : '0;
  end

endmodule
